ivl_ovl_win_unchange_mon: RTL and testbench
===========================================

// Module: ivl_ovl_win_unchange_mon
// PURPOSE
//  Receiving end of the window-unchange stimulus protocol (start_event / test_expr / end_event).
//  Tracks the window and flags any change of test_expr inside an open window.
//  Flags X/Z on test_expr, start_event or end_event, and keeps saturating violation/window counters.
//  Sits beside the OVL checkers in ivl_uvm benches as a self-reporting monitor for UVM scoreboards.
// PARAMETERS
//  WIDTH    4  width of test_expr
//  CNT_W    8  width of viol_count and win_count (saturating)
// PORTS
//  clock        in   1        rising-edge clock, single clock domain
//  reset        in   1        synchronous, active-low reset
//  enable       in   1        1 = checking active; 0 = fire/counters frozen, FSM still tracks
//  test_expr    in   WIDTH    monitored expression
//  start_event  in   1        opens window when sampled 1 in IDLE
//  end_event    in   1        closes window when sampled 1 in WINDOW
//  fire         out  4        registered 1-cycle pulses: [0] value change, [1] X/Z test_expr,
//                             [2] X/Z start_event, [3] X/Z end_event
//  window_open  out  1        1 while FSM in WINDOW
//  ref_value    out  WIDTH    last sampled known test_expr inside window
//  viol_count   out  CNT_W    number of cycles with any fire bit set
//  win_count    out  CNT_W    completed windows (end_event accepted)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, fire=0, window_open=0, ref_value=0, both counts=0.
//  - IDLE:
//    - start_event==1 -> ref_value<=test_expr, go WINDOW next cycle.
//    - start_event X/Z -> fire[2] next cycle, stay IDLE.
//    - end_event ignored (no fire, even if X/Z).
//  - WINDOW, every posedge from cycle after start up to and including the end cycle:
//    - test_expr has X/Z -> fire[1]; no compare; ref_value unchanged.
//    - else test_expr!==ref_value -> fire[0]; ref_value<=test_expr (fires once per change, not every cycle).
//    - end_event==1 -> compare still done this cycle; win_count+1; go IDLE.
//    - end_event X/Z -> fire[3], stay WINDOW.
//    - start_event (any value, incl. X/Z) ignored in WINDOW.
//  - Start and end in the same cycle while IDLE: start wins, end not honoured until the next cycle.
//  - fire latency: 1 cycle after the sampling edge; several bits may be set together.
//  - viol_count +1 per cycle with fire!=0; counters saturate at all-ones, no wrap.
//  - enable==0: fire forced 0, counters hold, FSM and ref_value update normally.
//  - Reset mid-window: aborts window, win_count not incremented.
//  - X/Z detection uses reduction-XOR ===1'bx; simulation-only semantics are acceptable (bench IP).
// STRUCTURE
//  - ivl_ovl_pkg (shared): typedef enum logic {IDLE,WINDOW} win_state_e; localparams FIRE_CHG=0,
//    FIRE_XEXPR=1, FIRE_XSTART=2, FIRE_XEND=3.
//  - Sub-module ivl_ovl_sat_counter #(CNT_W) (clock, reset, inc, count): used twice.
//  - One FSM always_ff; fire decode in always_comb, registered in the same FSM block.
// TESTING (100 MHz ivl_uvm_ovl_clk_gen; drive on posedge via wait_clks-style tasks)
//  1. reset=0, start=1 with test_expr 4'h1 -> fire=0, window_open=0, counts 0 throughout.
//  2. reset=1, start with 4'h5, hold 4 cycles, end -> fire=0, win_count=1, window_open 0 after end.
//  3. start with 4'h5, change to 4'h4 after 2 cycles, end -> exactly one fire[0] pulse,
//     viol_count=1, ref_value=4'h4.
//  4. In window: test_expr=4'b1Z00 -> fire[1]; then 4'b11X0 on the end cycle -> fire[1],
//     window closes, win_count increments.
//  5. IDLE start_event=1'bX then 1'bZ -> fire[2] on two consecutive cycles, window_open stays 0.
//  6. Open window, end_event=1'bZ, then 3 cycles later 1'bX -> two fire[3] pulses, window still open;
//     then end=1 closes it. Repeat with enable=0 -> no fire, counters unchanged.

Source files
------------

// File: rtl/ivl_ovl_pkg.sv
// ivl_ovl_pkg: shared state type, fire bit positions and X/Z helper for the OVL monitors
package ivl_ovl_pkg;

    typedef enum logic {IDLE, WINDOW} win_state_e;

    localparam int FIRE_CHG    = 0;
    localparam int FIRE_XEXPR  = 1;
    localparam int FIRE_XSTART = 2;
    localparam int FIRE_XEND   = 3;

    // True when a (reduced) bit is neither 0 nor 1; never true in a two-state simulator
    function automatic logic is_xz(input logic b);
        return (b !== 1'b0) && (b !== 1'b1);
    endfunction

endpackage

// File: rtl/ivl_ovl_sat_counter.sv
// ivl_ovl_sat_counter: event counter that sticks at all-ones instead of wrapping
module ivl_ovl_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d, count_q;

    // Next count: step only while below the saturation value
    always_comb count_d = (inc && count_q != '1) ? count_q + {{(CNT_W-1){1'b0}}, 1'b1} : count_q;

    // Count register, cleared by the active-low reset
    always_ff @(posedge clock) count_q <= !reset ? '0 : count_d;

    assign count = count_q;

endmodule

// File: rtl/ivl_ovl_win_unchange_mon.sv
// ivl_ovl_win_unchange_mon: tracks start/end windows and flags test_expr changes and X/Z inputs
module ivl_ovl_win_unchange_mon
    import ivl_ovl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] test_expr,
    input  logic             start_event,
    input  logic             end_event,
    output logic [3:0]       fire,
    output logic             window_open,
    output logic [WIDTH-1:0] ref_value,
    output logic [CNT_W-1:0] viol_count,
    output logic [CNT_W-1:0] win_count
);

    win_state_e       state_d, state_q;
    logic [3:0]       fire_raw, fire_d, fire_q;
    logic [WIDTH-1:0] ref_d, ref_q;
    logic             end_acc;

    // Next-state, reference tracking and fire decode; enable only masks reporting
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        fire_raw = '0;
        end_acc  = 1'b0;
        if (state_q == IDLE) begin
            if (is_xz(start_event)) begin
                fire_raw[FIRE_XSTART] = 1'b1;
            end else if (start_event) begin
                ref_d   = test_expr;
                state_d = WINDOW;
            end
        end else begin
            if (is_xz(^test_expr)) begin
                fire_raw[FIRE_XEXPR] = 1'b1;
            end else if (test_expr != ref_q) begin
                fire_raw[FIRE_CHG] = 1'b1;
                ref_d              = test_expr;
            end
            if (is_xz(end_event)) begin
                fire_raw[FIRE_XEND] = 1'b1;
            end else if (end_event) begin
                state_d = IDLE;
                end_acc = 1'b1;
            end
        end
        fire_d = enable ? fire_raw : '0;
    end

    // FSM, reference value and registered fire pulses
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            fire_q  <= '0;
            ref_q   <= '0;
        end else begin
            state_q <= state_d;
            fire_q  <= fire_d;
            ref_q   <= ref_d;
        end
    end

    ivl_ovl_sat_counter #(.CNT_W(CNT_W)) u_viol (
        .clock(clock),
        .reset(reset),
        .inc  (|fire_d),
        .count(viol_count)
    );

    ivl_ovl_sat_counter #(.CNT_W(CNT_W)) u_win (
        .clock(clock),
        .reset(reset),
        .inc  (end_acc && enable),
        .count(win_count)
    );

    assign fire        = fire_q;
    assign window_open = (state_q == WINDOW);
    assign ref_value   = ref_q;

endmodule

// File: tb/tb_ivl_ovl_win_unchange_mon.sv
// tb_ivl_ovl_win_unchange_mon: directed vectors with a cycle-stamped expectation queue and monitor
module tb_ivl_ovl_win_unchange_mon;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [3:0] test_expr = 4'h0;
    logic       start_event = 1'b0;
    logic       end_event = 1'b0;
    logic [3:0] fire;
    logic       window_open;
    logic [3:0] ref_value;
    logic [7:0] viol_count;
    logic [7:0] win_count;

    typedef struct {
        int         due;
        logic [3:0] f;
        logic       o;
        logic [3:0] rv;
        logic [7:0] vc;
        logic [7:0] wc;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   k;
    logic four_state;
    logic xb, zb;
    logic [3:0] xe1, xe2;

    ivl_ovl_win_unchange_mon #(.WIDTH(4), .CNT_W(8)) dut (
        .clock      (clk),
        .reset      (reset),
        .enable     (enable),
        .test_expr  (test_expr),
        .start_event(start_event),
        .end_event  (end_event),
        .fire       (fire),
        .window_open(window_open),
        .ref_value  (ref_value),
        .viol_count (viol_count),
        .win_count  (win_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            total++;
            if (fire !== e.f || window_open !== e.o || ref_value !== e.rv ||
                viol_count !== e.vc || win_count !== e.wc) begin
                bad++;
                $display("FAIL %s: got fire=%b open=%b ref=%h viol=%0d win=%0d, want fire=%b open=%b ref=%h viol=%0d win=%0d",
                         e.nm, fire, window_open, ref_value, viol_count, win_count,
                         e.f, e.o, e.rv, e.vc, e.wc);
            end
        end
    end

    task automatic step(input logic r, input logic en, input logic [3:0] t, input logic s,
                        input logic d, input logic [3:0] f, input logic o, input logic [3:0] rv,
                        input int vc, input int wc, input string nm);
        exp_t x;
        reset       = r;
        enable      = en;
        test_expr   = t;
        start_event = s;
        end_event   = d;
        x.due = cyc + 1;
        x.f   = f;
        x.o   = o;
        x.rv  = rv;
        x.vc  = vc[7:0];
        x.wc  = wc[7:0];
        x.nm  = nm;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] probe;
        probe      = 2'b0x;
        four_state = (probe[0] !== 1'b0) && (probe[0] !== 1'b1);
        k          = four_state ? 1 : 0;
        xb         = four_state ? 1'bx : 1'b0;
        zb         = four_state ? 1'bz : 1'b0;
        xe1        = four_state ? 4'b1z00 : 4'h5;
        xe2        = four_state ? 4'b11x0 : 4'h5;
        @(posedge clk);
        #1;
        // reset held: start must be ignored
        for (int i = 0; i < 3; i++) step(0, 1, 4'h1, 1, 0, 4'h0, 0, 4'h0, 0, 0, "reset_hold");
        // clean window, no change
        step(1, 1, 4'h5, 1, 0, 4'h0, 1, 4'h5, 0, 0, "t2_start");
        for (int i = 0; i < 4; i++) step(1, 1, 4'h5, 0, 0, 4'h0, 1, 4'h5, 0, 0, "t2_hold");
        step(1, 1, 4'h5, 0, 1, 4'h0, 0, 4'h5, 0, 1, "t2_end");
        step(1, 1, 4'h5, 0, 0, 4'h0, 0, 4'h5, 0, 1, "t2_idle");
        // single change inside a window
        step(1, 1, 4'h5, 1, 0, 4'h0, 1, 4'h5, 0, 1, "t3_start");
        step(1, 1, 4'h5, 0, 0, 4'h0, 1, 4'h5, 0, 1, "t3_hold0");
        step(1, 1, 4'h5, 0, 0, 4'h0, 1, 4'h5, 0, 1, "t3_hold1");
        step(1, 1, 4'h4, 0, 0, 4'h1, 1, 4'h4, 1, 1, "t3_change");
        step(1, 1, 4'h4, 0, 0, 4'h0, 1, 4'h4, 1, 1, "t3_nochange");
        step(1, 1, 4'h4, 0, 1, 4'h0, 0, 4'h4, 1, 2, "t3_end");
        // X/Z test_expr, including on the end cycle
        step(1, 1, 4'h5, 1, 0, 4'h0, 1, 4'h5, 1, 2, "t4_start");
        step(1, 1, xe1, 0, 0, four_state ? 4'h2 : 4'h0, 1, 4'h5, 1 + k, 2, "t4_xexpr");
        step(1, 1, 4'h5, 0, 0, 4'h0, 1, 4'h5, 1 + k, 2, "t4_known");
        step(1, 1, xe2, 0, 1, four_state ? 4'h2 : 4'h0, 0, 4'h5, 1 + 2 * k, 3, "t4_xend_cycle");
        // X/Z start in IDLE
        step(1, 1, 4'h5, xb, 0, four_state ? 4'h4 : 4'h0, 0, 4'h5, 1 + 3 * k, 3, "t5_xstart");
        step(1, 1, 4'h5, zb, 0, four_state ? 4'h4 : 4'h0, 0, 4'h5, 1 + 4 * k, 3, "t5_zstart");
        step(1, 1, 4'h5, 0, 0, 4'h0, 0, 4'h5, 1 + 4 * k, 3, "t5_quiet");
        // X/Z end in WINDOW, enabled
        step(1, 1, 4'h3, 1, 0, 4'h0, 1, 4'h3, 1 + 4 * k, 3, "t6_start");
        step(1, 1, 4'h3, 0, zb, four_state ? 4'h8 : 4'h0, 1, 4'h3, 1 + 5 * k, 3, "t6_zend");
        step(1, 1, 4'h3, 0, 0, 4'h0, 1, 4'h3, 1 + 5 * k, 3, "t6_gap0");
        step(1, 1, 4'h3, 0, 0, 4'h0, 1, 4'h3, 1 + 5 * k, 3, "t6_gap1");
        step(1, 1, 4'h3, 0, xb, four_state ? 4'h8 : 4'h0, 1, 4'h3, 1 + 6 * k, 3, "t6_xend");
        step(1, 1, 4'h3, 0, 1, 4'h0, 0, 4'h3, 1 + 6 * k, 4, "t6_end");
        // same sequence with enable low: FSM and ref move, reporting frozen
        step(1, 0, 4'h3, 1, 0, 4'h0, 1, 4'h3, 1 + 6 * k, 4, "t6d_start");
        step(1, 0, 4'h3, 0, zb, 4'h0, 1, 4'h3, 1 + 6 * k, 4, "t6d_zend");
        step(1, 0, 4'h6, 0, 0, 4'h0, 1, 4'h6, 1 + 6 * k, 4, "t6d_change");
        step(1, 0, 4'h6, 0, 0, 4'h0, 1, 4'h6, 1 + 6 * k, 4, "t6d_gap");
        step(1, 0, 4'h6, 0, xb, 4'h0, 1, 4'h6, 1 + 6 * k, 4, "t6d_xend");
        step(1, 0, 4'h6, 0, 1, 4'h0, 0, 4'h6, 1 + 6 * k, 4, "t6d_end");
        // start and end together in IDLE: start wins
        step(1, 1, 4'h2, 1, 1, 4'h0, 1, 4'h2, 1 + 6 * k, 4, "same_cycle");
        step(1, 1, 4'h2, 0, 1, 4'h0, 0, 4'h2, 1 + 6 * k, 5, "same_next_end");
        // reset mid-window aborts without counting
        step(1, 1, 4'h7, 1, 0, 4'h0, 1, 4'h7, 1 + 6 * k, 5, "mid_start");
        step(0, 1, 4'h7, 0, 1, 4'h0, 0, 4'h0, 0, 0, "mid_reset");
        // window counter saturation
        for (int i = 1; i <= 260; i++) begin
            step(1, 1, 4'h0, 1, 0, 4'h0, 1, 4'h0, 0, (i - 1 > 255) ? 255 : i - 1, "sat_start");
            step(1, 1, 4'h0, 0, 1, 4'h0, 0, 4'h0, 0, (i > 255) ? 255 : i, "sat_end");
        end
        repeat (2) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
